// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 16;
    localparam int unsigned ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: writes clear, reservations set, reservation wins a tie.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REGS-1:0]         clr_vec,
    input  logic                        rsv_en,
    input  logic [$clog2(NUM_REGS)-1:0] rsv_addr,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr_a,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr_b,
    output logic                        busy_a_c,
    output logic                        busy_b_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_vec;

    always_comb begin
        set_vec = '0;
        if (rsv_en) begin
            set_vec[rsv_addr] = 1'b1;
        end
    end

    // Set is OR-ed after the clear so a same-cycle reservation keeps the bit high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
        end
    end

    assign busy_a_c = busy_q[rd_addr_a];
    assign busy_b_c = busy_q[rd_addr_b];

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational reads, two clocked writes,
// optional zero register and write-first bypass, collision flag, busy scoreboard.
module reg_file_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_REGS)-1:0] RA,
    input  logic [$clog2(NUM_REGS)-1:0] RB,
    input  logic [$clog2(NUM_REGS)-1:0] RW,
    input  logic [DATA_W-1:0]           Bus_W,
    input  logic                        RegRw,
    input  logic [DATA_W-1:0]           Bus_W1,
    input  logic                        Rs1Rw,
    input  logic                        RsvEn,
    input  logic [$clog2(NUM_REGS)-1:0] RsvAddr,
    output logic [DATA_W-1:0]           Bus_A,
    output logic [DATA_W-1:0]           Bus_B,
    output logic                        Busy_A,
    output logic                        Busy_B,
    output logic                        WrConflict
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                we0;
    logic                we1;
    logic                conflict;
    logic                rsv_ok;
    logic [NUM_REGS-1:0] clr_vec;

    // Effective enables: register 0 is read-only when ZERO_REG is set.
    always_comb begin
        we0    = RegRw;
        we1    = Rs1Rw;
        rsv_ok = RsvEn;
        if (ZERO_REG) begin
            if (RW == '0) we0 = 1'b0;
            if (RA == '0) we1 = 1'b0;
            if (RsvAddr == '0) rsv_ok = 1'b0;
        end
        conflict = we0 && we1 && (RW == RA);
        clr_vec  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            clr_vec[i] = (we0 && (RW == ADDR_W'(i))) || (we1 && (RA == ADDR_W'(i)));
        end
    end

    // Port 0 is assigned last so it wins a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we1) regs[RA] <= Bus_W1;
            if (we0) regs[RW] <= Bus_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WrConflict <= 1'b0;
        end else begin
            WrConflict <= conflict;
        end
    end

    // Bypass is gated by rst_n so reads stay zero while reset is held.
    always_comb begin
        Bus_A = regs[RA];
        Bus_B = regs[RB];
        if (ZERO_REG && (RA == '0)) Bus_A = DATA_W'(ZERO_WORD);
        if (ZERO_REG && (RB == '0)) Bus_B = DATA_W'(ZERO_WORD);
        if (BYPASS && rst_n) begin
            if (we0 && (RW == RA)) begin
                Bus_A = Bus_W;
            end else if (we1) begin
                Bus_A = Bus_W1;
            end
            if (we0 && (RW == RB)) begin
                Bus_B = Bus_W;
            end else if (we1 && (RA == RB)) begin
                Bus_B = Bus_W1;
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_vec   (clr_vec),
        .rsv_en    (rsv_ok),
        .rsv_addr  (RsvAddr),
        .rd_addr_a (RA),
        .rd_addr_b (RB),
        .busy_a_c  (Busy_A),
        .busy_b_c  (Busy_B)
    );

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: two DUT configurations share stimulus; a queue carries expected outputs to a monitor.
module tb_reg_file_param;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        ra, rb, rw, rsv_addr;
    logic [31:0]       bus_w, bus_w1;
    logic              reg_rw, rs1_rw, rsv_en;
    logic [1:0][31:0]  bus_a, bus_b;
    logic [1:0]        busy_a, busy_b, wr_conf;

    int checks   = 0;
    int failures = 0;

    // Instance 0: zero register, no bypass. Instance 1: no zero register, write-first bypass.
    reg_file_param #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .RA(ra), .RB(rb), .RW(rw), .Bus_W(bus_w), .RegRw(reg_rw),
        .Bus_W1(bus_w1), .Rs1Rw(rs1_rw), .RsvEn(rsv_en), .RsvAddr(rsv_addr),
        .Bus_A(bus_a[0]), .Bus_B(bus_b[0]), .Busy_A(busy_a[0]), .Busy_B(busy_b[0]),
        .WrConflict(wr_conf[0]));

    reg_file_param #(.ZERO_REG(1'b0), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .RA(ra), .RB(rb), .RW(rw), .Bus_W(bus_w), .RegRw(reg_rw),
        .Bus_W1(bus_w1), .Rs1Rw(rs1_rw), .RsvEn(rsv_en), .RsvAddr(rsv_addr),
        .Bus_A(bus_a[1]), .Bus_B(bus_b[1]), .Busy_A(busy_a[1]), .Busy_B(busy_b[1]),
        .WrConflict(wr_conf[1]));

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [1:0][31:0] a;
        logic [1:0][31:0] b;
        logic [1:0]       ba;
        logic [1:0]       bb;
        logic [1:0]       wc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference state: architectural register contents, busy flags, pending conflict flag.
    logic [31:0] mem  [2][16];
    bit          busy [2][16];
    bit          conf [2];

    function automatic bit zr(input int k);
        return k == 0;
    endfunction

    function automatic bit byp(input int k);
        return k == 1;
    endfunction

    task automatic chk(input string tag, input int k, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d %s: got %h expected %h", tag, k, what, act, exp);
        end
    endtask

    task automatic step(input bit rst, input logic [3:0] a_addr, input logic [3:0] b_addr,
                        input logic [3:0] w_addr, input logic [31:0] wd, input bit wen,
                        input logic [31:0] wd1, input bit wen1, input bit rsv,
                        input logic [3:0] rsva, input string tag);
        exp_t e;
        bit   e0, e1;
        logic [31:0] av, bv;
        @(negedge clk);
        rst_n = rst; ra = a_addr; rb = b_addr; rw = w_addr; bus_w = wd; reg_rw = wen;
        bus_w1 = wd1; rs1_rw = wen1; rsv_en = rsv; rsv_addr = rsva;
        e.tag = tag;
        for (int k = 0; k < 2; k++) begin
            e0 = wen  && !(zr(k) && w_addr == 4'd0);
            e1 = wen1 && !(zr(k) && a_addr == 4'd0);
            if (!rst) begin
                e.a[k] = '0; e.b[k] = '0; e.ba[k] = 1'b0; e.bb[k] = 1'b0; e.wc[k] = 1'b0;
            end else begin
                av = (zr(k) && a_addr == 4'd0) ? 32'd0 : mem[k][a_addr];
                bv = (zr(k) && b_addr == 4'd0) ? 32'd0 : mem[k][b_addr];
                if (byp(k)) begin
                    if (e0 && w_addr == a_addr) av = wd;
                    else if (e1) av = wd1;
                    if (e0 && w_addr == b_addr) bv = wd;
                    else if (e1 && a_addr == b_addr) bv = wd1;
                end
                e.a[k] = av; e.b[k] = bv;
                e.ba[k] = busy[k][a_addr]; e.bb[k] = busy[k][b_addr]; e.wc[k] = conf[k];
            end
        end
        q.push_back(e);
        // Advance the reference to the state after the coming rising edge.
        for (int k = 0; k < 2; k++) begin
            e0 = wen  && !(zr(k) && w_addr == 4'd0);
            e1 = wen1 && !(zr(k) && a_addr == 4'd0);
            if (!rst) begin
                for (int r = 0; r < 16; r++) begin
                    mem[k][r] = '0; busy[k][r] = 1'b0;
                end
                conf[k] = 1'b0;
            end else begin
                conf[k] = e0 && e1 && (w_addr == a_addr);
                if (e1) begin mem[k][a_addr] = wd1; busy[k][a_addr] = 1'b0; end
                if (e0) begin mem[k][w_addr] = wd;  busy[k][w_addr] = 1'b0; end
                if (rsv && !(zr(k) && rsva == 4'd0)) busy[k][rsva] = 1'b1;
            end
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents one result mid-phase.
    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk(mon_e.tag, k, "Bus_A",      bus_a[k],          mon_e.a[k]);
                chk(mon_e.tag, k, "Bus_B",      bus_b[k],          mon_e.b[k]);
                chk(mon_e.tag, k, "Busy_A",     32'(busy_a[k]),    32'(mon_e.ba[k]));
                chk(mon_e.tag, k, "Busy_B",     32'(busy_b[k]),    32'(mon_e.bb[k]));
                chk(mon_e.tag, k, "WrConflict", 32'(wr_conf[k]),   32'(mon_e.wc[k]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; ra = '0; rb = '0; rw = '0; bus_w = '0; bus_w1 = '0;
        reg_rw = 1'b0; rs1_rw = 1'b0; rsv_en = 1'b0; rsv_addr = '0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_hold");
        step(1, 0, 0, 3, 32'h12345678, 1, 0, 0, 0, 0, "wr3");
        step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, "rd3");
        step(1, 3, 0, 5, 32'h87654321, 1, 32'h11112222, 1, 0, 0, "dual_wr");
        step(1, 3, 5, 0, 0, 0, 0, 0, 0, 0, "dual_rd");
        step(1, 7, 7, 7, 32'hAAAA0000, 1, 32'hBBBB0000, 1, 0, 0, "collide");
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, "conf_hi");
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, "conf_lo");
        step(1, 0, 0, 0, 32'hAAAAAAAA, 1, 0, 0, 0, 0, "wr_r0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rsv_r0");
        step(1, 0, 0, 0, 32'h5555AAAA, 1, 32'h0BADBEEF, 1, 0, 0, "collide_r0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rd_r0");
        step(1, 4, 0, 0, 0, 0, 0, 0, 1, 4, "rsv4");
        step(1, 4, 4, 4, 32'h44444444, 1, 0, 0, 1, 4, "wr_rsv4");
        step(1, 4, 0, 4, 32'h44440000, 1, 0, 0, 0, 0, "wr4");
        step(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, "busy4_clr");
        step(1, 0, 0, 9, 32'h00000009, 1, 0, 0, 0, 0, "wr9");
        step(1, 9, 9, 9, 32'hCAFEF00D, 1, 0, 0, 0, 0, "byp9");
        step(1, 9, 2, 0, 0, 0, 32'hFEEDFACE, 1, 0, 0, "byp_p1");
        step(1, 9, 5, 0, 0, 0, 0, 0, 1, 5, "rsv5");
        step(0, 9, 5, 9, 32'h99999999, 1, 32'h77777777, 1, 1, 9, "async_rst");
        step(1, 9, 5, 0, 0, 0, 0, 0, 0, 0, "post_rst");
        step(1, 3, 7, 0, 0, 0, 0, 0, 0, 0, "post_rst2");

        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 79) != 0,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 15)), "random");
        end

        @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
